cursor_backup: RTL and testbench
================================

// Module: cursor_backup
// PURPOSE
//  Read-side counterpart of the cursor drawer. Before the cursor is drawn, it reads the
//  framebuffer pixels under the cursor footprint and stores them in an internal buffer.
//  On restore it writes them back through the same out_x/out_y/paint/px_data write port
//  the drawer uses, so a moving cursor leaves the canvas intact.
//  Sits in PAINT_ASM between the paint controller and the framebuffer arbiter.
// PARAMETERS
//  CUR_W  3  footprint width in pixels (1..8)
//  CUR_H  3  footprint height in pixels (1..8)
// PORTS
//  clk           in   1  system clock
//  rst           in   1  asynchronous, active-high reset
//  init_save     in   1  1-cycle pulse: back up the footprint at (in_x,in_y)
//  init_restore  in   1  1-cycle pulse: write the backed-up pixels back
//  in_x          in   6  footprint top-left x, sampled with init_save
//  in_y          in   6  footprint top-left y, sampled with init_save
//  rd_en         out  1  framebuffer read strobe
//  rd_x          out  6  read address x
//  rd_y          out  6  read address y
//  rd_data       in   8  read data, valid exactly 1 cycle after rd_en
//  out_x         out  6  write address x
//  out_y         out  6  write address y
//  paint         out  1  write strobe, one pixel per asserted cycle
//  px_data       out  8  write data
//  busy          out  1  high from the cycle after an accepted init until done
//  backup_done   out  1  1-cycle pulse at the end of a save or restore
// BEHAVIOUR
//  - Reset: every output is 0, FSM=IDLE, valid flag cleared, buffer contents don't-care.
//  - FSM: IDLE -> SAVE_RD <-> SAVE_CAP -> DONE -> IDLE; IDLE -> RESTORE -> DONE -> IDLE.
//  - Init pulses are accepted only in IDLE and ignored while busy=1.
//  - If init_save and init_restore are high together, restore wins and save is dropped.
//  - Save: latch (in_x,in_y) as base. Visit N=CUR_W*CUR_H pixels in row-major order
//    (dx inner, dy outer). SAVE_RD drives rd_en=1, rd_x=base_x+dx, rd_y=base_y+dy.
//    SAVE_CAP writes rd_data to buf[dy*CUR_W+dx] and holds rd_en=0.
//    Timing from an init in cycle 0: rd_en in cycles 1,3,...,2N-1; backup_done in cycle 2N+1.
//    At the end of the save, set valid=1.
//  - Restore: uses the latched base, not the current in_x/in_y. Same row-major order.
//    paint=1 with out_x/out_y/px_data=buf[i] in cycles 1..N; backup_done in cycle N+1.
//    valid stays 1 after a restore, so a repeated restore rewrites the same data.
//  - Restore with valid=0: no paint cycles; backup_done pulses in cycle 1.
//  - Address arithmetic is 6-bit modulo 64: x=62, dx=2 gives rd_x=0 (wrap, no clipping).
//  - paint and rd_en are never high in the same cycle. When paint=0, out_x/out_y/px_data
//    hold their last values; when rd_en=0, rd_x/rd_y hold their last values.
//  - Reset mid-operation aborts immediately: outputs go to 0 and valid is cleared.
// TESTING
//  - Save, 3x3, base (10,20), memory model rd_data={x[3:0],y[3:0]} -> 9 reads (10..12,20..22)
//    row-major; backup_done in cycle 19; busy high in cycles 1..19.
//  - Restore after that save, with in_x/in_y changed to (40,40) -> paint cycles 1..9 write
//    (10,20)=0xA4 ... (12,22)=0xC6; backup_done in cycle 10.
//  - Save at (62,63), then restore -> addresses x {62,63,0}, y {63,0,1}; written data
//    matches the data read.
//  - Restore right after reset -> no paint; backup_done in cycle 1.
//  - init_save pulsed during a restore -> ignored. Simultaneous init_save+init_restore in
//    IDLE -> only the restore runs.
//  - rst asserted in cycle 7 of a save -> all outputs 0 immediately. A following restore
//    produces no paint (valid=0).

Source files
------------

// File: rtl/cursor_backup.sv
// Cursor footprint backup: reads the pixels under the cursor into a local buffer
// and later paints them back through the drawer's write port.
module cursor_backup #(
  parameter int CUR_W = 3,
  parameter int CUR_H = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_save,
  input  logic       init_restore,
  input  logic [5:0] in_x,
  input  logic [5:0] in_y,
  output logic       rd_en,
  output logic [5:0] rd_x,
  output logic [5:0] rd_y,
  input  logic [7:0] rd_data,
  output logic [5:0] out_x,
  output logic [5:0] out_y,
  output logic       paint,
  output logic [7:0] px_data,
  output logic       busy,
  output logic       backup_done
);

  localparam int N     = CUR_W * CUR_H;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SAVE_RD  = 3'd1;
  localparam logic [2:0] SAVE_CAP = 3'd2;
  localparam logic [2:0] RESTORE  = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [5:0]       base_x_q, base_x_d, base_y_q, base_y_d;
  logic [2:0]       dx_q, dx_d, dy_q, dy_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             rd_en_q, rd_en_d;
  logic [5:0]       rd_x_q, rd_x_d, rd_y_q, rd_y_d;
  logic [5:0]       out_x_q, out_x_d, out_y_q, out_y_d;
  logic             paint_q, paint_d;
  logic [7:0]       px_data_q, px_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [7:0]       buf_mem [0:(2**IDX_W)-1];
  logic             buf_we;

  logic             last_col, last_px;
  logic [2:0]       nx, ny;
  logic [IDX_W-1:0] idx_inc;

  // Row-major walk: dx inner, dy outer.
  always_comb begin
    last_col = (dx_q == 3'(CUR_W - 1));
    last_px  = last_col && (dy_q == 3'(CUR_H - 1));
    nx       = last_col ? 3'd0 : dx_q + 3'd1;
    ny       = last_col ? dy_q + 3'd1 : dy_q;
    idx_inc  = idx_q + IDX_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    base_x_d  = base_x_q;
    base_y_d  = base_y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    rd_en_d   = 1'b0;
    rd_x_d    = rd_x_q;
    rd_y_d    = rd_y_q;
    out_x_d   = out_x_q;
    out_y_d   = out_y_q;
    paint_d   = 1'b0;
    px_data_d = px_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    buf_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (init_restore) begin
          busy_d = 1'b1;
          dx_d   = 3'd0;
          dy_d   = 3'd0;
          idx_d  = '0;
          if (valid_q) begin
            state_d   = RESTORE;
            paint_d   = 1'b1;
            out_x_d   = base_x_q;
            out_y_d   = base_y_q;
            px_data_d = buf_mem['0];
          end else begin
            // Nothing backed up: finish at once without painting.
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else if (init_save) begin
          busy_d   = 1'b1;
          base_x_d = in_x;
          base_y_d = in_y;
          dx_d     = 3'd0;
          dy_d     = 3'd0;
          idx_d    = '0;
          state_d  = SAVE_RD;
          rd_en_d  = 1'b1;
          rd_x_d   = in_x;
          rd_y_d   = in_y;
        end
      end
      SAVE_RD: state_d = SAVE_CAP;
      SAVE_CAP: begin
        buf_we = 1'b1;
        if (last_px) begin
          state_d = DONE;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end else begin
          dx_d    = nx;
          dy_d    = ny;
          idx_d   = idx_inc;
          state_d = SAVE_RD;
          rd_en_d = 1'b1;
          rd_x_d  = base_x_q + {3'b000, nx};
          rd_y_d  = base_y_q + {3'b000, ny};
        end
      end
      RESTORE: begin
        if (last_px) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          dx_d      = nx;
          dy_d      = ny;
          idx_d     = idx_inc;
          paint_d   = 1'b1;
          out_x_d   = base_x_q + {3'b000, nx};
          out_y_d   = base_y_q + {3'b000, ny};
          px_data_d = buf_mem[idx_inc];
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      base_x_q  <= '0;
      base_y_q  <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_x_q    <= '0;
      rd_y_q    <= '0;
      out_x_q   <= '0;
      out_y_q   <= '0;
      paint_q   <= 1'b0;
      px_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_x_q  <= base_x_d;
      base_y_q  <= base_y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      rd_en_q   <= rd_en_d;
      rd_x_q    <= rd_x_d;
      rd_y_q    <= rd_y_d;
      out_x_q   <= out_x_d;
      out_y_q   <= out_y_d;
      paint_q   <= paint_d;
      px_data_q <= px_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Buffer contents are don't-care after reset; validity is tracked by valid_q.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[idx_q] <= rd_data;
  end

  assign rd_en       = rd_en_q;
  assign rd_x        = rd_x_q;
  assign rd_y        = rd_y_q;
  assign out_x       = out_x_q;
  assign out_y       = out_y_q;
  assign paint       = paint_q;
  assign px_data     = px_data_q;
  assign busy        = busy_q;
  assign backup_done = done_q;

endmodule

// File: tb/tb_cursor_backup.sv
// Directed bench for cursor_backup: table of save/restore transactions plus a
// hand-written reset-abort sequence, against a framebuffer returning {x[3:0],y[3:0]}.
module tb_cursor_backup;
  localparam int CW      = 3;
  localparam int CH      = 3;
  localparam int NPX     = CW * CH;
  localparam int TXN_CYC = 22;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_save = 1'b0, init_restore = 1'b0;
  logic [5:0] in_x = '0, in_y = '0;
  logic       rd_en, paint, busy, backup_done;
  logic [5:0] rd_x, rd_y, out_x, out_y;
  logic [7:0] rd_data = '0, px_data;

  int n_checks = 0;
  int n_fail   = 0;

  cursor_backup #(.CUR_W(CW), .CUR_H(CH)) dut (
    .clk(clk), .rst(rst), .init_save(init_save), .init_restore(init_restore),
    .in_x(in_x), .in_y(in_y), .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
    .rd_data(rd_data), .out_x(out_x), .out_y(out_y), .paint(paint),
    .px_data(px_data), .busy(busy), .backup_done(backup_done)
  );

  always #5 clk = ~clk;

  // Framebuffer model: one-cycle read latency.
  always @(posedge clk) if (rd_en) rd_data <= {rd_x[3:0], rd_y[3:0]};

  typedef struct {
    bit         s;
    bit         r;
    logic [5:0] x;
    logic [5:0] y;
    int         inj;
    int         n_rd;
    int         n_pt;
    int         done;
    int         bx;
    int         by;
    int         first_px;
    int         last_px;
  } vec_t;

  vec_t vecs [9];

  int         rd_cyc [64];
  logic [5:0] rd_xs [64], rd_ys [64];
  int         pt_cyc [64];
  logic [5:0] pt_xs [64], pt_ys [64];
  logic [7:0] pt_d [64];
  int         n_rd, n_pt, done_cyc, n_done, overlap;
  logic [5:0] rd_x_at_done;
  bit         busy_log [0:TXN_CYC];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic run_txn(input bit s, input bit r, input logic [5:0] x,
                         input logic [5:0] y, input int inj);
    n_rd = 0; n_pt = 0; done_cyc = -1; n_done = 0; overlap = 0; rd_x_at_done = '0;
    @(negedge clk);
    init_save = s; init_restore = r; in_x = x; in_y = y;
    for (int c = 1; c <= TXN_CYC; c++) begin
      @(negedge clk);
      init_save    = (c == inj);
      init_restore = 1'b0;
      if (rd_en && n_rd < 64) begin
        rd_cyc[n_rd] = c; rd_xs[n_rd] = rd_x; rd_ys[n_rd] = rd_y; n_rd++;
      end
      if (paint && n_pt < 64) begin
        pt_cyc[n_pt] = c; pt_xs[n_pt] = out_x; pt_ys[n_pt] = out_y; pt_d[n_pt] = px_data;
        n_pt++;
      end
      if (backup_done) begin
        if (done_cyc < 0) begin
          done_cyc = c;
          rd_x_at_done = rd_x;
        end
        n_done++;
      end
      if (rd_en && paint) overlap++;
      busy_log[c] = busy;
    end
    init_save = 1'b0;
  endtask

  task automatic check_txn(input string tag, input vec_t v);
    int         busy_err;
    logic [5:0] ex, ey;
    check({tag, " reads"}, n_rd, v.n_rd);
    check({tag, " paints"}, n_pt, v.n_pt);
    check({tag, " done_cycle"}, done_cyc, v.done);
    check({tag, " done_pulses"}, n_done, 1);
    check({tag, " rd_paint_overlap"}, overlap, 0);
    busy_err = 0;
    for (int c = 1; c <= TXN_CYC; c++)
      if (busy_log[c] != (c <= v.done)) busy_err++;
    check({tag, " busy_window_errs"}, busy_err, 0);
    for (int i = 0; i < v.n_rd && i < n_rd; i++) begin
      ex = 6'(v.bx + i % CW);
      ey = 6'(v.by + i / CW);
      check($sformatf("%s rd%0d cycle", tag, i), rd_cyc[i], 2 * i + 1);
      check($sformatf("%s rd%0d xy", tag, i), {rd_xs[i], rd_ys[i]}, {ex, ey});
    end
    if (v.n_rd > 0)
      check({tag, " rd_x_hold"}, rd_x_at_done, 6'(v.bx + CW - 1));
    for (int i = 0; i < v.n_pt && i < n_pt; i++) begin
      ex = 6'(v.bx + i % CW);
      ey = 6'(v.by + i / CW);
      check($sformatf("%s pt%0d cycle", tag, i), pt_cyc[i], i + 1);
      check($sformatf("%s pt%0d xy", tag, i), {pt_xs[i], pt_ys[i]}, {ex, ey});
      check($sformatf("%s pt%0d data", tag, i), pt_d[i], {ex[3:0], ey[3:0]});
    end
    if (v.n_pt > 0 && n_pt >= v.n_pt) begin
      check({tag, " first_px"}, pt_d[0], v.first_px);
      check({tag, " last_px"}, pt_d[v.n_pt-1], v.last_px);
    end
  endtask

  initial begin
    vec_t rv;
    //            s  r  x   y   inj n_rd n_pt done bx  by  first last
    vecs[0] = '{0, 1, 0,  0,  0,  0,   0,   1,   0,  0,  0,    0};
    vecs[1] = '{1, 0, 10, 20, 0,  9,   0,   19,  10, 20, 0,    0};
    vecs[2] = '{0, 1, 40, 40, 0,  0,   9,   10,  10, 20, 'hA4, 'hC6};
    vecs[3] = '{0, 1, 0,  0,  0,  0,   9,   10,  10, 20, 'hA4, 'hC6};
    vecs[4] = '{1, 1, 30, 30, 0,  0,   9,   10,  10, 20, 'hA4, 'hC6};
    vecs[5] = '{1, 0, 62, 63, 0,  9,   0,   19,  62, 63, 0,    0};
    vecs[6] = '{0, 1, 5,  5,  0,  0,   9,   10,  62, 63, 'hEF, 'h01};
    vecs[7] = '{0, 1, 7,  7,  3,  0,   9,   10,  62, 63, 'hEF, 'h01};
    vecs[8] = '{0, 1, 9,  9,  0,  0,   9,   10,  62, 63, 'hEF, 'h01};

    #1;
    check("reset outputs", int'(|{rd_en, rd_x, rd_y, out_x, out_y, paint, px_data, busy, backup_done}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("idle outputs after reset", int'(|{rd_en, paint, busy, backup_done}), 0);

    for (int t = 0; t < 9; t++) begin
      run_txn(vecs[t].s, vecs[t].r, vecs[t].x, vecs[t].y, vecs[t].inj);
      check_txn($sformatf("vec%0d", t), vecs[t]);
    end

    // Reset in cycle 7 of a save aborts it and clears the valid flag.
    @(negedge clk);
    init_save = 1'b1; in_x = 6'd5; in_y = 6'd5;
    for (int c = 1; c < 7; c++) begin
      @(negedge clk);
      init_save = 1'b0;
    end
    check("busy before abort", int'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("outputs on abort", int'(|{rd_en, rd_x, rd_y, out_x, out_y, paint, px_data, busy, backup_done}), 0);
    @(negedge clk);
    check("outputs held in reset", int'(|{rd_en, rd_x, rd_y, out_x, out_y, paint, px_data, busy, backup_done}), 0);
    rst = 1'b0;
    run_txn(1'b0, 1'b1, 6'd10, 6'd20, 0);
    rv = '{0, 1, 10, 20, 0, 0, 0, 1, 0, 0, 0, 0};
    check_txn("post_abort_restore", rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end
endmodule
